// File: rtl/cve2_csr.sv
// Version constant for the staged CSR primitive; the top module lives in cve2_csr_staged.sv.
package cve2_csr_file_unused_pkg;
  localparam int unsigned CsrStagedVersion = 1;
endpackage

// File: rtl/cve2_csr_pkg.sv
// Shared types for the staged CSR primitive.
package cve2_csr_pkg;

  typedef enum logic {
    CsrIdle   = 1'b0,
    CsrStaged = 1'b1
  } csr_stage_e;

endpackage

// File: rtl/cve2_csr_shadow_store.sv
// Committed register with optional inverted shadow copy and sticky mismatch flag.
// q_o updates on the edge that samples we_i; err_o rises one cycle after a mismatch appears.
module cve2_csr_shadow_store #(
  parameter int unsigned     Width      = 32,
  parameter logic [Width-1:0] ResetValue = '0,
  parameter bit              ShadowCopy = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  input  logic             we_i,
  output logic [Width-1:0] q_o,
  output logic             err_o
);

  logic [Width-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (we_i) q_d = d_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= ResetValue;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

  generate
    if (ShadowCopy) begin : gen_shadow
      logic [Width-1:0] shadow_q, shadow_d;
      logic             err_q, err_d;

      // The shadow holds the inverse, so a stuck or flipped bit in either copy shows up.
      always_comb begin
        shadow_d = shadow_q;
        if (we_i) shadow_d = ~d_i;
        err_d = err_q | (q_q != ~shadow_q);
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          shadow_q <= ~ResetValue;
          err_q    <= 1'b0;
        end else begin
          shadow_q <= shadow_d;
          err_q    <= err_d;
        end
      end

      assign err_o = err_q;
    end else begin : gen_no_shadow
      assign err_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/cve2_csr_staged.sv
// CSR with per-bit write mask, optional two-write staged commit and shadow integrity check.
// Commit visible on rd_data_o at the sampling edge; commit_o/update_err_o pulse the cycle after.
module cve2_csr_staged
  import cve2_csr_pkg::*;
#(
  parameter int unsigned      Width       = 32,
  parameter logic [Width-1:0] ResetValue  = '0,
  parameter logic [Width-1:0] WriteMask   = '1,
  parameter bit               StagedWrite = 1'b1,
  parameter bit               ShadowCopy  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             wr_en_i,
  input  logic             abort_i,
  output logic [Width-1:0] rd_data_o,
  output logic             staged_o,
  output logic             commit_o,
  output logic             update_err_o,
  output logic             storage_err_o
);

  logic [Width-1:0] eff;
  logic [Width-1:0] stage_q, stage_d;
  csr_stage_e       state_q, state_d;
  logic             commit_q, commit_d;
  logic             upd_err_q, upd_err_d;
  logic             store_we;

  // Read-only bits are forced to their reset value before any store or compare.
  assign eff = (wr_data_i & WriteMask) | (ResetValue & ~WriteMask);

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    commit_d  = 1'b0;
    upd_err_d = 1'b0;
    store_we  = 1'b0;
    if (!StagedWrite) begin
      if (wr_en_i) begin
        store_we = 1'b1;
        commit_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        CsrIdle: begin
          if (wr_en_i) begin
            stage_d = eff;
            state_d = CsrStaged;
          end
        end
        CsrStaged: begin
          if (abort_i) begin
            state_d = CsrIdle;
          end else if (wr_en_i) begin
            state_d = CsrIdle;
            if (eff == stage_q) begin
              store_we = 1'b1;
              commit_d = 1'b1;
            end else begin
              upd_err_d = 1'b1;
            end
          end
        end
        default: state_d = CsrIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= CsrIdle;
      stage_q   <= ResetValue;
      commit_q  <= 1'b0;
      upd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      commit_q  <= commit_d;
      upd_err_q <= upd_err_d;
    end
  end

  cve2_csr_shadow_store #(
    .Width      (Width),
    .ResetValue (ResetValue),
    .ShadowCopy (ShadowCopy)
  ) u_store (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (eff),
    .we_i  (store_we),
    .q_o   (rd_data_o),
    .err_o (storage_err_o)
  );

  assign staged_o     = StagedWrite ? (state_q == CsrStaged) : 1'b0;
  assign commit_o     = commit_q;
  assign update_err_o = upd_err_q;

`ifndef SYNTHESIS
  wr_en_known_a: assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown(wr_en_i));
  abort_known_a: assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown(abort_i));
`endif

endmodule
